rr_grant_arbiter4: RTL and testbench

//  4-requester round-robin arbiter sharing one resource (bus, display digit, memory bank).

---
 rtl/rr_grant_arbiter4_pkg.sv | 24 ++
 rtl/rr_grant_arbiter4_dec.sv | 20 ++
 rtl/rr_grant_arbiter4.sv | 66 ++++++
 tb/tb_rr_grant_arbiter4.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/rr_grant_arbiter4_pkg.sv
// rr_grant_arbiter4_pkg: shared state codes, default hold limit and rotate-priority search helper
package rr_grant_arbiter4_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int MAX_HOLD_DEFAULT = 8;

    // Returns {found, index} of the first set bit of r, scanning p, p+1, p+2, p+3 (mod 4).
    // Scanning from the far end backwards lets the nearest hit overwrite the others.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] k;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            k = p + 2'(i);
            if (r[k]) res = {1'b1, k};
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter4_dec.sv
// dec2to4_unit: gate-level 2-to-4 decoder; ports a1,a0 (binary in), y3..y0 (one-hot out)
module dec2to4_unit (
    input  logic a1,
    input  logic a0,
    output logic y3,
    output logic y2,
    output logic y1,
    output logic y0
);

    logic n1, n0;

    not g_n1 (n1, a1);
    not g_n0 (n0, a0);
    and g_y0 (y0, n1, n0);
    and g_y1 (y1, n1, a0);
    and g_y2 (y2, a1, n0);
    and g_y3 (y3, a1, a0);

endmodule

// File: rtl/rr_grant_arbiter4.sv
// rr_grant_arbiter4: 4-way round-robin arbiter with hold timeout; ports clk, reset (sync high), req[3:0] in; grant[3:0], grant_idx[1:0], grant_valid out
module rr_grant_arbiter4
    import rr_grant_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid
);

    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [3:0]          owner_oh;
    logic [2:0]          pick;
    logic                busy, owner_req, timeout, rearb, take;

    dec2to4_unit u_dec (
        .a1 (idx_q[1]),
        .a0 (idx_q[0]),
        .y3 (owner_oh[3]),
        .y2 (owner_oh[2]),
        .y1 (owner_oh[1]),
        .y0 (owner_oh[0])
    );

    // While busy the owner is masked out of the search: on release its bit is already 0,
    // and on timeout it must not win again ahead of waiting requesters.
    always_comb begin
        busy      = state_q == ST_BUSY;
        owner_req = req[idx_q];
        timeout   = hold_q == HOLD_W'(MAX_HOLD - 1);
        pick      = rr_pick(busy ? req & ~owner_oh : req, ptr_q);
        rearb     = !busy || !owner_req || timeout;
        take      = rearb && pick[2];
        state_d   = (take || (busy && owner_req)) ? ST_BUSY : ST_IDLE;
        idx_d     = take ? pick[1:0] : (state_d == ST_BUSY ? idx_q : 2'd0);
        ptr_d     = take ? pick[1:0] + 2'd1 : ptr_q;
        hold_d    = rearb ? '0 : hold_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            ptr_q   <= 2'd0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign grant_valid = state_q == ST_BUSY;
    assign grant_idx   = idx_q;
    assign grant       = owner_oh & {4{grant_valid}};

endmodule

// File: tb/tb_rr_grant_arbiter4.sv
// tb_rr_grant_arbiter4: directed and randomized checks of the round-robin arbiter against a behavioural model
module tb_rr_grant_arbiter4;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;

    int n_checks = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // model: owner (-1 = nobody), next search start, cycles the current owner has held the grant
    int m_owner = -1;
    int m_ptr = 0;
    int m_held = 0;

    rr_grant_arbiter4 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // first requester found walking from 'start' around the ring, skipping 'skip'; -1 if none
    function automatic int first_req(input logic [3:0] r, input int start, input int skip);
        for (int i = 0; i < 4; i++) begin
            int c;
            c = (start + i) % 4;
            if (c != skip && r[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
        end else if (m_owner < 0 || !req[m_owner]) begin
            w = first_req(req, m_ptr, -1);
            m_owner = w;
            m_held  = 1;
            if (w >= 0) m_ptr = (w + 1) % 4;
        end else if (m_held == MAX_HOLD) begin
            w = first_req(req, m_ptr, m_owner);
            m_held = 1;
            if (w >= 0) begin
                m_owner = w;
                m_ptr   = (w + 1) % 4;
            end
        end else begin
            m_held++;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_grant", grant, m_owner < 0 ? 4'b0000 : 4'(1 << m_owner));
            check("cmp_idx", {2'b00, grant_idx}, m_owner < 0 ? 4'd0 : 4'(m_owner));
            check("cmp_valid", {3'b000, grant_valid}, {3'b000, m_owner >= 0});
            check("cmp_onehot", 4'($countones(grant) <= 1), 4'd1);
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        req = 4'b0000;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // 1: reset with all requests high
        req = 4'b1111;
        tick();
        cmp_en = 1'b1;
        check("t1_rst_grant", grant, 4'b0000);
        check("t1_rst_valid", {3'b000, grant_valid}, 4'd0);
        tick();
        check("t1_rst_grant2", grant, 4'b0000);
        reset = 1'b0;
        tick();
        check("t1_first_grant", grant, 4'b0001);
        check("t1_first_idx", {2'b00, grant_idx}, 4'd0);
        // 2: single requester, then release to idle
        req = 4'b0000;
        tick();
        req = 4'b0100;
        tick();
        check("t2_grant", grant, 4'b0100);
        req = 4'b0000;
        tick();
        check("t2_idle_grant", grant, 4'b0000);
        check("t2_idle_valid", {3'b000, grant_valid}, 4'd0);
        // 3: back-to-back rotation with each owner releasing after 2 cycles
        do_reset();
        req = 4'b1111;
        tick();
        check("t3_start", grant, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t3_hold", grant, 4'(1 << k));
            req = 4'b1111 & ~4'(1 << k);
            tick();
            check("t3_next", grant, 4'(1 << ((k + 1) % 4)));
            req = 4'b1111;
        end
        // 4: timeout alternation between two constant requesters
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 24; i++) begin
            tick();
            check("t4_timeout", grant, ((i / 8) % 2) != 0 ? 4'b0010 : 4'b0001);
        end
        // 5: lone requester never loses the grant at timeout
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t5_lone", grant, 4'b0001);
        end
        // 6: reset mid-grant restarts the search at 0
        do_reset();
        req = 4'b0100;
        tick();
        tick();
        check("t6_owner2", grant, 4'b0100);
        reset = 1'b1;
        tick();
        check("t6_rst_grant", grant, 4'b0000);
        check("t6_rst_idx", {2'b00, grant_idx}, 4'd0);
        check("t6_rst_valid", {3'b000, grant_valid}, 4'd0);
        reset = 1'b0;
        req = 4'b1100;
        tick();
        check("t6_restart", grant, 4'b0100);
        // random traffic with sticky requests and occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
